// File: rtl/spi_ram_pkg.sv
// Shared definitions for the spi_ram memory stage: frame command encoding and widths.
package spi_ram_pkg;
  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;
endpackage

// File: rtl/spi_ram_if.sv
// Frame/reply bundle between the SPI slave (master side) and spi_ram (slave side).
interface spi_ram_if;
  import spi_ram_pkg::*;

  // rx_valid qualifies din for exactly one cycle per frame; there is no ready,
  // every valid cycle is consumed. tx_valid qualifies dout and stays high until
  // a non-read frame is accepted.
  logic [FRAME_W-1:0] din;
  logic               rx_valid;
  logic [DATA_W-1:0]  dout;
  logic               tx_valid;

  modport master (output din, output rx_valid, input dout, input tx_valid);
  modport slave  (input din, input rx_valid, output dout, output tx_valid);
endinterface

// File: rtl/spi_ram.sv
// Command-decoding RAM behind the SPI slave. Define SPI_RAM_ADDR_AUTO_INC_EN to make
// executed data writes/reads post-increment their address.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_ram_if.slave   bus
);

  typedef logic [ADDR_SIZE-1:0] addr_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  addr_t             wr_addr;
  addr_t             rd_addr;
  logic              wr_vld;
  logic              rd_vld;
  logic [DATA_W-1:0] dout_q;
  logic              tx_valid_q;
  cmd_t              cmd;
  logic              do_write;

  assign cmd      = cmd_t'(bus.din[FRAME_W-1:FRAME_W-2]);
  assign do_write = bus.rx_valid && (cmd == CMD_WR_DATA) && wr_vld;

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;

  // Array kept out of the reset domain so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= bus.din[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_vld     <= 1'b0;
      rd_vld     <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else if (bus.rx_valid) begin
      tx_valid_q <= 1'b0;
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr <= bus.din[ADDR_SIZE-1:0];
          wr_vld  <= 1'b1;
        end
        CMD_WR_DATA: begin
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
          if (wr_vld) wr_addr <= wr_addr + addr_t'(1);
`endif
        end
        CMD_RD_ADDR: begin
          rd_addr <= bus.din[ADDR_SIZE-1:0];
          rd_vld  <= 1'b1;
        end
        CMD_RD_DATA: begin
          dout_q     <= rd_vld ? mem[rd_addr] : '0;
          tx_valid_q <= 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
          if (rd_vld) rd_addr <= rd_addr + addr_t'(1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: command decode, sticky tx_valid, dropped writes, idle hold, reset.
module tb_spi_ram;
  import spi_ram_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  spi_ram_if bus ();

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [9:0] frame);
    @(negedge clk);
    bus.din      = frame;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_dout, input logic exp_tx);
    check({tag, "_dout"}, bus.dout, exp_dout);
    check({tag, "_tx"}, {7'd0, bus.tx_valid}, {7'd0, exp_tx});
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.din      = '0;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_out("reset", 8'h00, 1'b0);
    rst_n = 1'b1;

    // Read with no read address loaded returns zero.
    send(10'h300);
    check_out("rd_no_addr", 8'h00, 1'b1);

    send(10'h012);
    check_out("wr_addr_clears_tx", 8'h00, 1'b0);
    send(10'h1A5);
    send(10'h212);
    send(10'h300);
    check_out("basic_read", 8'hA5, 1'b1);

    send(10'h2FF);
    check_out("tx_drop_on_rd_addr", 8'hA5, 1'b0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.din      = 10'($urandom_range(0, 1023));
      bus.rx_valid = 1'b0;
      @(posedge clk);
      #1;
      check_out("idle_hold", 8'hA5, 1'b0);
    end
    send(10'h212);
    send(10'h300);
    check_out("idle_mem_intact", 8'hA5, 1'b1);

    // Seed mem[0], reset, then a WR_DATA with no write address must be dropped.
    send(10'h000);
    send(10'h15A);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_out("reset_again", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(10'h1C3);
    send(10'h000);
    send(10'h200);
    send(10'h300);
    check_out("dropped_write", 8'h5A, 1'b1);

    // Write lands at edge N, read at edge N+1 sees it.
    send(10'h060);
    send(10'h260);
    send(10'h1E1);
    send(10'h300);
    check_out("raw_consecutive", 8'hE1, 1'b1);

    send(10'h040);
    send(10'h13C);
    send(10'h041);
    send(10'h17E);
    send(10'h240);
    send(10'h300);
    check_out("b2b_first", 8'h3C, 1'b1);
    send(10'h300);
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
    check_out("b2b_second", 8'h7E, 1'b1);

    send(10'h0FF);
    send(10'h111);
    send(10'h122);
    send(10'h2FF);
    send(10'h300);
    check_out("autoinc_rd0", 8'h11, 1'b1);
    send(10'h300);
    check_out("autoinc_rd1_wrap", 8'h22, 1'b1);
`else
    check_out("b2b_second", 8'h3C, 1'b1);

    send(10'h031);
    send(10'h177);
    send(10'h030);
    send(10'h111);
    send(10'h122);
    send(10'h230);
    send(10'h300);
    check_out("no_inc_overwrite", 8'h22, 1'b1);
    send(10'h231);
    send(10'h300);
    check_out("no_inc_neighbor", 8'h77, 1'b1);
`endif

    // Asynchronous reset mid-cycle while a read reply is held.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(10'h300);
    check_out("rd_vld_cleared", 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
